// File: rtl/eth_clk_seq_pkg.sv
// Shared types and defaults for the Ethernet clock/reset sequencer.
// The timer-width helper sizes the one timer shared by every sequencer state.
package eth_clk_seq_pkg;

   typedef enum logic [2:0] {
      MMCM_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN,
      FAIL
   } seq_state_t;

   localparam int unsigned DEF_MMCM_RST_CYCLES = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT    = 65536;
   localparam int unsigned DEF_STABLE_CYCLES   = 1024;
   localparam int unsigned DEF_N_DOMAINS       = 3;
   localparam int unsigned DEF_RELEASE_GAP     = 64;
   localparam int unsigned DEF_MAX_RETRIES     = 4;
   localparam int unsigned DEF_CNT_W           = 8;

   // Bits needed to count up to (largest dwell - 1); never narrower than one bit.
   function automatic int unsigned timer_width(
      input int unsigned i_c0,
      input int unsigned i_c1,
      input int unsigned i_c2,
      input int unsigned i_c3
   );
      int unsigned w_max;
      w_max = i_c0;
      if (i_c1 > w_max) w_max = i_c1;
      if (i_c2 > w_max) w_max = i_c2;
      if (i_c3 > w_max) w_max = i_c3;
      return (w_max <= 1) ? 1 : $clog2(w_max);
   endfunction

endpackage

// File: rtl/eth_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, with a
// parameterised value loaded by the synchronous reset.
module eth_sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/eth_clk_rst_seq.sv
// Ethernet clock manager sequencer: MMCM reset pulse, lock wait and qualification,
// ordered release of downstream domain resets, lock-loss restart and retry-limited failure.
module eth_clk_rst_seq
   import eth_clk_seq_pkg::*;
#(
   parameter int unsigned MMCM_RST_CYCLES = DEF_MMCM_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES   = DEF_STABLE_CYCLES,
   parameter int unsigned N_DOMAINS       = DEF_N_DOMAINS,
   parameter int unsigned RELEASE_GAP     = DEF_RELEASE_GAP,
   parameter int unsigned MAX_RETRIES     = DEF_MAX_RETRIES,
   parameter int unsigned CNT_W           = DEF_CNT_W
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 clk_locked_i,
   input  logic                 sw_restart_i,
   output logic                 mmcm_rst_o,
   output logic [N_DOMAINS-1:0] rst_dom_o,
   output logic                 ready_o,
   output logic                 lock_fail_o,
   output logic [CNT_W-1:0]     retry_cnt_o,
   output logic [CNT_W-1:0]     lock_loss_cnt_o
);

   localparam int unsigned TW = timer_width(MMCM_RST_CYCLES, LOCK_TIMEOUT,
                                            STABLE_CYCLES, RELEASE_GAP);
   localparam int unsigned IW = $clog2(N_DOMAINS + 1);

   // The timer reloads to zero and counts down, so a dwell of N cycles ends when
   // it reads -(N-1); the reset value of zero therefore already starts a full pulse.
   localparam logic [TW-1:0] T_MMCM_END   = TW'(0) - TW'(MMCM_RST_CYCLES - 1);
   localparam logic [TW-1:0] T_LOCK_END   = TW'(0) - TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] T_STABLE_END = TW'(0) - TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] T_GAP_END    = TW'(0) - TW'(RELEASE_GAP - 1);

   localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(MAX_RETRIES - 1);
   localparam logic [IW-1:0]    REL_LAST   = IW'(N_DOMAINS);

   logic                 w_lock_s;

   seq_state_t           r_state;
   logic [TW-1:0]        r_timer;
   logic [IW-1:0]        r_rel;
   logic [CNT_W-1:0]     r_retry;
   logic [CNT_W-1:0]     r_loss;

   seq_state_t           w_state;
   logic [TW-1:0]        w_timer;
   logic [IW-1:0]        w_rel;
   logic [CNT_W-1:0]     w_retry;
   logic [CNT_W-1:0]     w_loss;
   logic [N_DOMAINS-1:0] w_dom;

   eth_sync_2ff #(
      .RST_VAL (1'b0)
   ) u_lock_sync (
      .i_clk (clk_in),
      .i_rst (rst_in),
      .i_d   (clk_locked_i),
      .o_q   (w_lock_s)
   );

   always_comb begin
      w_state = r_state;
      w_timer = r_timer - 1'b1;
      w_rel   = r_rel;
      w_retry = r_retry;
      w_loss  = r_loss;

      if (sw_restart_i) begin
         w_state = MMCM_RST;
         w_timer = '0;
         w_rel   = '0;
         w_retry = '0;
      end else if ((r_state == RELEASE || r_state == RUN) && !w_lock_s) begin
         w_state = MMCM_RST;
         w_timer = '0;
         w_rel   = '0;
         w_retry = '0;
         w_loss  = (r_loss == '1) ? r_loss : r_loss + 1'b1;
      end else begin
         unique case (r_state)
            MMCM_RST: begin
               if (r_timer == T_MMCM_END) begin
                  w_state = WAIT_LOCK;
                  w_timer = '0;
               end
            end
            WAIT_LOCK: begin
               if (w_lock_s) begin
                  w_state = STABLE;
                  w_timer = '0;
               end else if (r_timer == T_LOCK_END) begin
                  w_timer = '0;
                  if (r_retry == RETRY_LAST) begin
                     w_state = FAIL;
                  end else begin
                     w_state = MMCM_RST;
                     w_retry = r_retry + 1'b1;
                  end
               end
            end
            STABLE: begin
               if (!w_lock_s) begin
                  w_state = MMCM_RST;
                  w_timer = '0;
               end else if (r_timer == T_STABLE_END) begin
                  w_state = RELEASE;
                  w_timer = '0;
                  w_rel   = IW'(1);
               end
            end
            RELEASE: begin
               if (r_timer == T_GAP_END) begin
                  w_timer = '0;
                  if (r_rel == REL_LAST) begin
                     w_state = RUN;
                     w_retry = '0;
                  end else begin
                     w_rel = r_rel + 1'b1;
                  end
               end
            end
            RUN: begin
               w_timer = r_timer;
            end
            FAIL: begin
               w_timer = r_timer;
            end
            default: begin
               w_state = MMCM_RST;
               w_timer = '0;
            end
         endcase
      end
   end

   // Domain i is out of reset only once rel_idx has passed it, or in RUN.
   always_comb begin
      w_dom = '1;
      if (w_state == RUN) begin
         w_dom = '0;
      end else if (w_state == RELEASE) begin
         for (int unsigned i = 0; i < N_DOMAINS; i++) begin
            if (i < 32'(w_rel)) w_dom[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= MMCM_RST;
         r_timer     <= '0;
         r_rel       <= '0;
         r_retry     <= '0;
         r_loss      <= '0;
         mmcm_rst_o  <= 1'b1;
         rst_dom_o   <= '1;
         ready_o     <= 1'b0;
         lock_fail_o <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_timer     <= w_timer;
         r_rel       <= w_rel;
         r_retry     <= w_retry;
         r_loss      <= w_loss;
         mmcm_rst_o  <= (w_state == MMCM_RST) || (w_state == FAIL);
         rst_dom_o   <= w_dom;
         ready_o     <= (w_state == RUN);
         lock_fail_o <= (w_state == FAIL);
      end
   end

   assign retry_cnt_o     = r_retry;
   assign lock_loss_cnt_o = r_loss;

endmodule

// File: tb/tb_eth_clk_rst_seq.sv
// Bench for eth_clk_rst_seq: phase/elapsed-time reference model checked every cycle,
// plus directed scenarios with hand-computed cycle counts.
module tb_eth_clk_rst_seq;

   localparam int MR   = 4;
   localparam int LT   = 32;
   localparam int SC   = 8;
   localparam int ND   = 3;
   localparam int GAP  = 4;
   localparam int MAXR = 2;

   logic       clk_in = 1'b0;
   logic       rst_in;
   logic       clk_locked_i;
   logic       sw_restart_i;
   logic       mmcm_rst_o;
   logic [2:0] rst_dom_o;
   logic       ready_o;
   logic       lock_fail_o;
   logic [7:0] retry_cnt_o;
   logic [7:0] lock_loss_cnt_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk_in = ~clk_in;

   eth_clk_rst_seq #(
      .MMCM_RST_CYCLES (MR),
      .LOCK_TIMEOUT    (LT),
      .STABLE_CYCLES   (SC),
      .N_DOMAINS       (ND),
      .RELEASE_GAP     (GAP),
      .MAX_RETRIES     (MAXR),
      .CNT_W           (8)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .clk_locked_i    (clk_locked_i),
      .sw_restart_i    (sw_restart_i),
      .mmcm_rst_o      (mmcm_rst_o),
      .rst_dom_o       (rst_dom_o),
      .ready_o         (ready_o),
      .lock_fail_o     (lock_fail_o),
      .retry_cnt_o     (retry_cnt_o),
      .lock_loss_cnt_o (lock_loss_cnt_o)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(negedge clk_in);
   endtask

   // Reference model: a phase plus cycles spent in it; release progress is
   // derived arithmetically from time spent with lock qualified.
   typedef enum {PH_PULSE, PH_WAIT, PH_QUAL, PH_ON, PH_DEAD} phase_t;
   phase_t m_ph;
   int     m_t, m_retry, m_loss, m_fail, m_rel, exp_dom;
   bit     m_valid = 0;
   logic   m_s1, m_s2, ls;

   always @(posedge clk_in) begin
      ls   = m_s2;
      m_s2 = m_s1;
      m_s1 = clk_locked_i;
      if (rst_in) begin
         m_s1 = 0; m_s2 = 0;
         m_ph = PH_PULSE; m_t = 0; m_retry = 0; m_loss = 0; m_fail = 0;
         m_valid = 1;
      end else if (sw_restart_i) begin
         m_ph = PH_PULSE; m_t = 0; m_retry = 0; m_fail = 0;
      end else begin
         case (m_ph)
            PH_PULSE: if (m_t == MR - 1) begin m_ph = PH_WAIT; m_t = 0; end else m_t++;
            PH_WAIT: begin
               if (ls) begin m_ph = PH_QUAL; m_t = 0; end
               else if (m_t == LT - 1) begin
                  m_t = 0;
                  if (m_retry == MAXR - 1) begin m_ph = PH_DEAD; m_fail = 1; end
                  else begin m_retry++; m_ph = PH_PULSE; end
               end else m_t++;
            end
            PH_QUAL: begin
               if (!ls) begin m_ph = PH_PULSE; m_t = 0; end
               else if (m_t == SC - 1) begin m_ph = PH_ON; m_t = 0; end
               else m_t++;
            end
            PH_ON: begin
               if (!ls) begin
                  m_ph = PH_PULSE; m_t = 0; m_retry = 0;
                  if (m_loss < 255) m_loss++;
               end else begin
                  if (m_t < 10000) m_t++;
                  if (m_t == ND * GAP) m_retry = 0;
               end
            end
            default: ;
         endcase
      end
      #1;
      if (m_valid) begin
         exp_dom = 7;
         if (m_ph == PH_ON) begin
            m_rel = 1 + m_t / GAP;
            if (m_rel > ND) m_rel = ND;
            exp_dom = 7 & ~((1 << m_rel) - 1);
         end
         chk("mdl_mmcm_rst", mmcm_rst_o, (m_ph == PH_PULSE || m_ph == PH_DEAD) ? 1 : 0);
         chk("mdl_rst_dom", rst_dom_o, exp_dom);
         chk("mdl_ready", ready_o, (m_ph == PH_ON && m_t >= ND * GAP) ? 1 : 0);
         chk("mdl_lock_fail", lock_fail_o, m_fail);
         chk("mdl_retry_cnt", retry_cnt_o, m_retry);
         chk("mdl_lock_loss_cnt", lock_loss_cnt_o, m_loss);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, lows, rises;
      logic prev;
      rst_in = 1'b1; clk_locked_i = 1'b0; sw_restart_i = 1'b0;
      tick(3);
      chk("rst_mmcm", mmcm_rst_o, 1);
      chk("rst_dom", rst_dom_o, 3'b111);
      chk("rst_ready", ready_o, 0);
      chk("rst_fail", lock_fail_o, 0);
      chk("rst_retry", retry_cnt_o, 0);
      chk("rst_loss", lock_loss_cnt_o, 0);

      // Scenario 1: lock arrives 10 cycles after the MMCM reset falls
      rst_in = 1'b0;
      n = 0;
      while (mmcm_rst_o && n < 50) begin n++; tick(1); end
      chk("s1_mmcm_len", n, 4);
      tick(10);
      clk_locked_i = 1'b1;
      n = 0;
      while (rst_dom_o == 3'b111 && n < 100) begin tick(1); n++; end
      chk("s1_lock_to_first_rel", n, 11);
      chk("s1_dom_110", rst_dom_o, 3'b110);
      tick(4); chk("s1_dom_100", rst_dom_o, 3'b100);
      tick(4); chk("s1_dom_000", rst_dom_o, 3'b000);
      tick(3); chk("s1_ready_not_yet", ready_o, 0);
      tick(1); chk("s1_ready", ready_o, 1);

      // Scenario 4: lock drop in RUN
      tick(5);
      clk_locked_i = 1'b0;
      n = 0;
      while (rst_dom_o != 3'b111 && n < 20) begin tick(1); n++; end
      chk("s4_drop_to_rst", n, 3);
      chk("s4_ready_low", ready_o, 0);
      chk("s4_loss_cnt", lock_loss_cnt_o, 1);

      // Scenario 3: one-cycle glitch while lock is being qualified
      clk_locked_i = 1'b1;
      n = 0;
      while (mmcm_rst_o && n < 50) begin tick(1); n++; end
      chk("s3_mmcm_len", n, 4);
      tick(3);
      clk_locked_i = 1'b0;
      tick(1);
      clk_locked_i = 1'b1;
      n = 0;
      while (!mmcm_rst_o && n < 20) begin tick(1); n++; end
      chk("s3_glitch_to_mmcm", n, 2);
      chk("s3_dom", rst_dom_o, 3'b111);
      chk("s3_loss_cnt", lock_loss_cnt_o, 1);
      n = 0;
      while (!ready_o && n < 200) begin tick(1); n++; end
      chk("s3_reseq_ready", ready_o, 1);

      // Scenario 6: restart and lock drop land in the same cycle
      tick(2);
      clk_locked_i = 1'b0;
      tick(2);
      sw_restart_i = 1'b1;
      tick(1);
      sw_restart_i = 1'b0;
      chk("s6_dom", rst_dom_o, 3'b111);
      chk("s6_ready", ready_o, 0);
      chk("s6_loss_unchanged", lock_loss_cnt_o, 1);
      clk_locked_i = 1'b1;
      n = 0;
      while (rst_dom_o != 3'b110 && n < 200) begin tick(1); n++; end
      chk("s6_in_release", rst_dom_o, 3'b110);

      // Reset mid-RELEASE
      rst_in = 1'b1;
      clk_locked_i = 1'b0;
      tick(1);
      chk("rr_mmcm", mmcm_rst_o, 1);
      chk("rr_dom", rst_dom_o, 3'b111);
      chk("rr_ready", ready_o, 0);
      chk("rr_fail", lock_fail_o, 0);
      chk("rr_retry", retry_cnt_o, 0);
      chk("rr_loss", lock_loss_cnt_o, 0);
      tick(2);

      // Scenario 2: never lock
      rst_in = 1'b0;
      n = 0; lows = 0; rises = 0; prev = 1'b1;
      while (n < 300) begin
         if (!mmcm_rst_o) lows++;
         if (mmcm_rst_o && !prev) rises++;
         prev = mmcm_rst_o;
         if (lock_fail_o) break;
         tick(1);
         n++;
      end
      chk("s2_time_to_fail", n, 72);
      chk("s2_wait_cycles", lows, 64);
      chk("s2_mmcm_rises", rises, 2);
      chk("s2_fail", lock_fail_o, 1);
      chk("s2_retry", retry_cnt_o, 1);
      chk("s2_mmcm_held", mmcm_rst_o, 1);
      chk("s2_dom", rst_dom_o, 3'b111);

      // Scenario 5: software restart out of FAIL with lock present
      clk_locked_i = 1'b1;
      tick(3);
      chk("s5_still_failed", lock_fail_o, 1);
      sw_restart_i = 1'b1;
      tick(1);
      sw_restart_i = 1'b0;
      chk("s5_fail_clr", lock_fail_o, 0);
      chk("s5_retry_clr", retry_cnt_o, 0);
      chk("s5_mmcm", mmcm_rst_o, 1);
      chk("s5_dom", rst_dom_o, 3'b111);
      n = 1;
      while (!ready_o && n < 200) begin tick(1); n++; end
      chk("s5_restart_to_ready", n, 26);

      tick(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
